axi_read_arbiter_rr: RTL and testbench

Parametrised N-channel read arbiter and AXI4-lite read master. It replaces the fixed two-port (instruction/execute) read arbiter. Requesters (IFU, LSU, later DMA/debug) each raise a level request with an address. The block grants them round-robin, runs one AR/R transaction on the shared AXI4-lite read port, and returns data with a one-cycle finish pulse and a per-channel error flag.

---
 rtl/axi_read_arbiter_rr.sv | 167 ++++++++++++++++
 tb/tb_axi_read_arbiter_rr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_rr.sv
// N-channel round-robin read arbiter driving a single AXI4-lite read port.
// One AR/R transaction is in flight at a time; completion is reported by a one-cycle finish pulse.
module axi_read_arbiter_rr #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [NUM_CH-1:0]        finish,
    output logic [NUM_CH-1:0]        rsp_err,
    output logic [NUM_CH-1:0]        grant,
    output logic [ADDR_W-1:0]        araddr,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CH_W-1:0]     prio_r, prio_s;
    logic [NUM_CH-1:0]   grant_r, grant_s;
    logic [NUM_CH-1:0]   finish_r, finish_s;
    logic [NUM_CH-1:0]   rsp_err_r, rsp_err_s;
    logic [ADDR_W-1:0]   araddr_r, araddr_s;
    logic                arvalid_r, arvalid_s;
    logic                rready_r, rready_s;
    logic [DATA_W-1:0]   rsp_data_r, rsp_data_s;
    logic                pick_vld_s;
    logic [CH_W-1:0]     pick_idx_s;

    // First requesting channel at or after p, wrapping; returns {found, index}.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] r, input logic [CH_W-1:0] p);
        logic [CH_W:0] res;
        int            c;
        res = {(CH_W+1){1'b0}};
        // Walk from farthest to nearest so the nearest set channel is written last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = int'(p) + k;
            c = (c >= NUM_CH) ? (c - NUM_CH) : c;
            if (r[c]) begin
                res = {1'b1, CH_W'(c)};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        for (int k = 0; k < NUM_CH; k++) begin
            oh[k] = (int'(idx) == k);
        end
        return oh;
    endfunction

    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] idx);
        return (idx == CH_W'(NUM_CH - 1)) ? CH_W'(0) : (idx + CH_W'(1));
    endfunction

    // Round-robin selection among the live requests.
    always_comb begin
        {pick_vld_s, pick_idx_s} = rr_pick(req, prio_r);
    end

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        state_s    = state_r;
        prio_s     = prio_r;
        grant_s    = grant_r;
        araddr_s   = araddr_r;
        arvalid_s  = arvalid_r;
        rready_s   = rready_r;
        rsp_data_s = rsp_data_r;
        finish_s   = {NUM_CH{1'b0}};
        rsp_err_s  = {NUM_CH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_s   = onehot(pick_idx_s);
                    araddr_s  = req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
                    arvalid_s = 1'b1;
                    prio_s    = next_idx(pick_idx_s);
                    state_s   = ST_ADDR;
                end else begin
                    grant_s   = {NUM_CH{1'b0}};
                end
            end
            ST_ADDR: begin
                if (arvalid_r && arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = ST_DATA;
                end else begin
                    arvalid_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (rvalid) begin
                    rsp_data_s = rdata;
                    finish_s   = grant_r;
                    rsp_err_s  = (rresp != 2'b00) ? grant_r : {NUM_CH{1'b0}};
                    rready_s   = 1'b0;
                    state_s    = ST_DONE;
                end else begin
                    rready_s   = 1'b1;
                end
            end
            ST_DONE: begin
                grant_s = {NUM_CH{1'b0}};
                state_s = ST_IDLE;
            end
            default: begin
                grant_s   = {NUM_CH{1'b0}};
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any open handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            prio_r     <= CH_W'(0);
            grant_r    <= {NUM_CH{1'b0}};
            finish_r   <= {NUM_CH{1'b0}};
            rsp_err_r  <= {NUM_CH{1'b0}};
            araddr_r   <= {ADDR_W{1'b0}};
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            rsp_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            prio_r     <= prio_s;
            grant_r    <= grant_s;
            finish_r   <= finish_s;
            rsp_err_r  <= rsp_err_s;
            araddr_r   <= araddr_s;
            arvalid_r  <= arvalid_s;
            rready_r   <= rready_s;
            rsp_data_r <= rsp_data_s;
        end
    end

    assign grant    = grant_r;
    assign finish   = finish_r;
    assign rsp_err  = rsp_err_r;
    assign araddr   = araddr_r;
    assign arvalid  = arvalid_r;
    assign rready   = rready_r;
    assign rsp_data = rsp_data_r;

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Scoreboard bench for axi_read_arbiter_rr with three channels and a behavioural AXI slave.
// Expected grant order is derived per request batch from the round-robin rule.
module tb_axi_read_arbiter_rr;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        req = '0;
    logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0]        rsp_data;
    logic [NUM_CH-1:0]        finish, rsp_err, grant;
    logic [ADDR_W-1:0]        araddr;
    logic                     arvalid, rready;
    logic                     arready = 1'b0;
    logic [DATA_W-1:0]        rdata = '0;
    logic [1:0]               rresp = 2'b00;
    logic                     rvalid = 1'b0;

    axi_read_arbiter_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .rsp_data(rsp_data),
        .finish(finish), .rsp_err(rsp_err), .grant(grant), .araddr(araddr),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               ch;
        logic [ADDR_W-1:0] addr;
        int               exp_cyc;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   slave_mode = 1;   // 0 random, 1 zero-wait, 2 never respond, 3 fixed stalls
    int   model_prio = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32] + 32'h0000_0013};
    endfunction

    function automatic logic [NUM_CH-1:0] ch_bit(input int ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AXI slave: decisions taken from values seen at the falling edge, driven just after the rising edge.
    initial begin
        logic              ar_hs, r_hs, arv_seen, rr_seen, pend, go;
        logic [ADDR_W-1:0] a_seen, pa;
        int                ar_cnt, r_cnt;
        pend = 1'b0; pa = '0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            ar_hs = rst && arvalid && arready;
            r_hs  = rst && rvalid && rready;
            arv_seen = arvalid; rr_seen = rready; a_seen = araddr;
            @(posedge clk);
            #1;
            if (!rst) begin
                pend = 1'b0; rvalid = 1'b0; arready = 1'b0; ar_cnt = 0; r_cnt = 0;
                continue;
            end
            if (r_hs) begin rvalid = 1'b0; pend = 1'b0; end
            if (ar_hs) begin pend = 1'b1; pa = a_seen; r_cnt = 0; end
            ar_cnt = (arv_seen && !ar_hs) ? ar_cnt + 1 : 0;
            if (rr_seen && !r_hs) r_cnt++;
            case (slave_mode)
                1: begin arready = 1'b1; go = 1'b1; end
                2: begin arready = ($urandom_range(0, 3) != 0); go = 1'b0; end
                3: begin arready = (ar_cnt >= 5); go = (r_cnt >= 7); end
                default: begin arready = ($urandom_range(0, 3) != 0); go = ($urandom_range(0, 2) == 0); end
            endcase
            if (pend && !rvalid && go) begin
                rvalid = 1'b1;
                rdata  = mem_data(pa);
                rresp  = pa[1:0];
            end
        end
    end

    // Monitor: checks the address phase, handshake stability and each completion against the queue.
    initial begin
        logic              prev_arv, prev_hs;
        logic [ADDR_W-1:0] prev_addr;
        txn_t              t;
        prev_arv = 1'b0; prev_hs = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_arv = 1'b0;
                continue;
            end
            if (prev_arv && !prev_hs) begin
                check("arvalid_hold", 64'(arvalid), 64'd1);
                check("araddr_hold", 64'(araddr), 64'(prev_addr));
            end
            if (arvalid && arready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_ar: araddr 0x%0h with no pending request", araddr);
                end else begin
                    check("ar_grant", 64'(grant), 64'(ch_bit(exp_q[0].ch)));
                    check("araddr", 64'(araddr), 64'(exp_q[0].addr));
                end
            end
            if (rready) check("rready_phase", 64'({arvalid, |grant}), 64'd1);
            if (finish != '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_finish: finish 0x%0h with empty queue", finish);
                end else begin
                    t = exp_q.pop_front();
                    check("finish", 64'(finish), 64'(ch_bit(t.ch)));
                    check("fin_grant", 64'(grant), 64'(ch_bit(t.ch)));
                    check("rsp_data", 64'(rsp_data), 64'(mem_data(t.addr)));
                    check("rsp_err", 64'(rsp_err), (t.addr[1:0] != 2'b00) ? 64'(ch_bit(t.ch)) : 64'd0);
                    if (t.exp_cyc >= 0) check("latency", 64'(cyc), 64'(t.exp_cyc));
                end
            end else begin
                check("rsp_err_idle", 64'(rsp_err), 64'd0);
            end
            prev_arv  = arvalid;
            prev_hs   = arvalid && arready;
            prev_addr = araddr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        exp_q.delete();
        model_prio = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Raise a set of requests together; the model lists service order from the current pointer.
    task automatic run_batch(input logic [NUM_CH-1:0] set, input bit timed,
                             input bit use_fixed, input logic [ADDR_W-1:0] fixed_addr);
        logic [ADDR_W-1:0] a;
        int base, n, last, ch;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        base = cyc; n = 0; last = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch = (model_prio + k) % NUM_CH;
            if (set[ch]) begin
                a = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                if (use_fixed) a = fixed_addr;
                req_addr[ch*ADDR_W +: ADDR_W] = a;
                exp_q.push_back('{ch, a, timed ? base + 3 + 4 * n : -1});
                n++;
                last = ch;
            end
        end
        model_prio = (last + 1) % NUM_CH;
        req = set;
        for (int t = 0; t < 400 && req != '0; t++) begin
            @(negedge clk);
            req = req & ~finish;
        end
        if (req != '0) begin
            n_cmp++; n_err++;
            $display("FAIL batch_timeout: req 0x%0h never completed", req);
            do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] s;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        rst = 1'b1;

        slave_mode = 1;
        run_batch(3'b001, 1'b1, 1'b1, 64'h0000_0000_8000_0000);
        run_batch(3'b011, 1'b1, 1'b0, 64'd0);
        run_batch(3'b010, 1'b1, 1'b1, 64'h0000_0000_4000_0012);
        run_batch(3'b111, 1'b1, 1'b0, 64'd0);
        run_batch(3'b111, 1'b1, 1'b0, 64'd0);
        run_batch(3'b101, 1'b1, 1'b0, 64'd0);

        slave_mode = 3;
        run_batch(3'b100, 1'b0, 1'b0, 64'd0);
        run_batch(3'b011, 1'b0, 1'b0, 64'd0);

        slave_mode = 0;
        for (int b = 0; b < 40; b++) begin
            s = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            run_batch(s, 1'b0, 1'b0, 64'd0);
        end

        // Reset while the DATA phase is stalled; pointer must restart from channel 0.
        slave_mode = 1;
        run_batch(3'b001, 1'b0, 1'b0, 64'd0);
        slave_mode = 2;
        @(negedge clk);
        req_addr[1*ADDR_W +: ADDR_W] = 64'h0000_0001_2345_6780;
        exp_q.push_back('{1, 64'h0000_0001_2345_6780, -1});
        model_prio = 2;
        req = 3'b010;
        for (int t = 0; t < 100 && !rready; t++) @(negedge clk);
        check("stall_rready", 64'(rready), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_arvalid", 64'(arvalid), 64'd0);
        check("mid_rst_rready", 64'(rready), 64'd0);
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_finish", 64'(finish), 64'd0);
        check("mid_rst_araddr", 64'(araddr), 64'd0);
        req = '0;
        exp_q.delete();
        model_prio = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        slave_mode = 1;
        run_batch(3'b101, 1'b1, 1'b0, 64'd0);

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
